// File: rtl/credit_arbiter_pkg.sv
// Shared types and helpers for the credit arbiter (crossbar package).
// Optional checks are enabled with CREDIT_ARBITER_CHECK_EN in the files that import this.
package crossbar_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Widest request vector rr_next can scan.
  localparam int unsigned RR_MAX_INPUTS = 32;

  // First valid index at or after ptr, wrapping at n (not at a power of two).
  // Returns ptr when nothing is valid; callers only use it when some input is valid.
  function automatic int unsigned rr_next(input int unsigned ptr,
                                          input logic [RR_MAX_INPUTS-1:0] valid_vec,
                                          input int unsigned n);
    int unsigned idx;
    logic        found;
    rr_next = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < RR_MAX_INPUTS; i++) begin
      if (i < n && !found) begin
        idx = (ptr + i) % n;
        if (valid_vec[idx[4:0]]) begin
          rr_next = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/credit_arbiter_if.sv
// Valid/ready data stream with byte keep and packet last.
interface ndata_i #(
  parameter int DATA_W = 32
);
  localparam int KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] data;
  logic [KEEP_W-1:0] keep;
  logic              last;
  logic              valid;
  logic              ready;

  modport m (output data, keep, last, valid, input ready);
  modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/credit_arbiter_credit_counter.sv
// Shared credit pool: one credit per forwarded beat, refilled by credit_return.
// A return arriving at zero credits lets a beat through in the same cycle.
// CREDIT_ARBITER_CHECK_EN adds a sticky overflow flag and simulation assertions.
module credit_counter
  import crossbar_pkg::*;
#(
  parameter  int MAX_IN_TRANSIT = 16,
  localparam int CW             = $clog2(MAX_IN_TRANSIT) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          accept,
  input  logic          credit_return,
  output logic          pass,
  output logic [CW-1:0] credits_avail,
  output logic          err
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_IN_TRANSIT);

  logic [CW-1:0] count_q, count_d;
  logic          sat;

  assign pass          = (count_q != '0) || credit_return;
  assign credits_avail = count_q;
  assign sat           = credit_return && !accept && (count_q == MAX_C);

  // Next count: beat takes a credit, return gives one back, both cancel, full pool saturates.
  always_comb begin
    count_d = count_q;
    if (accept && !credit_return) begin
      count_d = count_q - CW'(1);
    end else if (!accept && credit_return && !sat) begin
      count_d = count_q + CW'(1);
    end
  end

  // Pool restarts full on reset; in-flight credits are deliberately forgotten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= MAX_C;
    end else begin
      count_q <= count_d;
    end
  end

`ifdef CREDIT_ARBITER_CHECK_EN
  logic err_q, err_d;

  // Sticky overflow flag.
  always_comb begin
    err_d = err_q | sat;
  end

  // Flag clears only on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

  a_return_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(credit_return))
    else $fatal(1, "credit_return is X/Z");
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !sat)
    else $fatal(1, "credit return with a full credit pool");
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/credit_arbiter.sv
// Packet-granular round-robin arbiter feeding one credit-limited stream.
// Grant is held until a last beat is accepted; each forwarded beat costs one credit.
// CREDIT_ARBITER_CHECK_EN enables the overflow flag and simulation assertions.
module credit_arbiter
  import crossbar_pkg::*;
#(
  parameter  int NUM_INPUTS     = 4,
  parameter  int MAX_IN_TRANSIT = 16,
  parameter  int DATA_W         = 32,
  localparam int GW             = $clog2(NUM_INPUTS),
  localparam int CW             = $clog2(MAX_IN_TRANSIT) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  ndata_i.s             in [NUM_INPUTS],
  ndata_i.m             out,
  input  logic          credit_return,
  output logic [GW-1:0] grant_id,
  output logic          busy,
  output logic [CW-1:0] credits_avail,
  output logic          err
);

  localparam int KW = DATA_W / 8;

  arb_state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;

  logic [DATA_W-1:0]     in_data [NUM_INPUTS];
  logic [KW-1:0]         in_keep [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] in_last;
  logic [NUM_INPUTS-1:0] in_valid;
  logic [NUM_INPUTS-1:0] in_ready;

  logic [DATA_W-1:0] sel_data;
  logic [KW-1:0]     sel_keep;
  logic              sel_last;
  logic              sel_valid;
  logic              out_valid;
  logic              accept;
  logic              pass;

  // Interface arrays only take constant indices, so flatten them here.
  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_in
    assign in_data[g]  = in[g].data;
    assign in_keep[g]  = in[g].keep;
    assign in_last[g]  = in[g].last;
    assign in_valid[g] = in[g].valid;
    assign in[g].ready = in_ready[g];
  end

  assign sel_data  = in_data[grant_q];
  assign sel_keep  = in_keep[grant_q];
  assign sel_last  = in_last[grant_q];
  assign sel_valid = in_valid[grant_q];

  assign out.data  = sel_data;
  assign out.keep  = sel_keep;
  assign out.last  = sel_last;
  assign out.valid = out_valid;

  assign accept        = out_valid && out.ready;
  assign busy          = (state_q == LOCKED);
  assign grant_id      = grant_q;

  credit_counter #(
    .MAX_IN_TRANSIT(MAX_IN_TRANSIT)
  ) u_credit (
    .clk          (clk),
    .rst_n        (rst_n),
    .accept       (accept),
    .credit_return(credit_return),
    .pass         (pass),
    .credits_avail(credits_avail),
    .err          (err)
  );

  // Zero-latency handshake through the granted input, gated by credit availability.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = '0;
    if (state_q == LOCKED) begin
      out_valid         = sel_valid && pass;
      in_ready[grant_q] = out.ready && pass;
    end
  end

  // Arbitration: pick in IDLE (one bubble per packet), release after an accepted last beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d = GW'(rr_next(32'(rr_q), RR_MAX_INPUTS'(in_valid), 32'(NUM_INPUTS)));
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          state_d = IDLE;
          rr_d    = (grant_q == GW'(NUM_INPUTS - 1)) ? '0 : grant_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

`ifdef CREDIT_ARBITER_CHECK_EN
  a_hold_while_stalled: assert property (@(posedge clk) disable iff (!rst_n)
      (busy && sel_valid && !in_ready[grant_q]) |=> ($stable(sel_data) && $stable(sel_last)))
    else $fatal(1, "granted input changed data/last while stalled");
`endif

endmodule

// File: doc/credit_arbiter.md
Name: credit_arbiter

Overview:
- Shares one credit-limited downstream path between NUM_INPUTS ndata streams.
- Round-robin arbitration at packet granularity: the grant is held until a beat with last=1 is accepted.
- Every beat forwarded consumes one credit from a shared pool; credit_return refills the pool.
- Sits in the crossbar in front of a credited section, e.g. a shared memory port or an accelerator pipeline with bounded in-flight capacity.

Parameters:
- NUM_INPUTS, 4, number of requesting streams (>=2).
- MAX_IN_TRANSIT, 16, credit pool size: the maximum number of beats in flight past the arbiter.

Ports:
- clk  input  1  clock; single clock domain.
- rst_n  input  1  synchronous, active-low reset.
- in[NUM_INPUTS]  ndata_i.s  interface array  requester streams (data, keep, last, valid, ready).
- out  ndata_i.m  interface  arbitrated stream toward the credited section.
- credit_return  input  1  one credit returned this cycle; must never be X after reset.
- grant_id  output  $clog2(NUM_INPUTS)  currently locked input; valid while busy=1.
- busy  output  1  arbiter is locked to an input (mid-packet).
- credits_avail  output  $clog2(MAX_IN_TRANSIT)+1  current credit count.
- err  output  1  sticky credit-overflow flag (see Optional Feature).

Behaviour:
- Reset values: state IDLE, credits_avail=MAX_IN_TRANSIT, rr pointer=0, grant_id=0, busy=0, err=0, out.valid=0, all in[i].ready=0.
- States:
  - IDLE: no data is forwarded. If any in[i].valid=1, pick the first valid index scanning from rr_ptr upward with wrap-around. Register it into grant_id and go to LOCKED next cycle. One bubble cycle per packet is accepted.
  - LOCKED: out.data/keep/last are driven from in[grant_id]. Let pass = (credits_avail!=0) || credit_return.
    - out.valid = in[grant_id].valid && pass.
    - in[grant_id].ready = out.ready && pass.
    - All other in[j].ready = 0.
  - Transition: on an accepted beat (out.valid && out.ready) with last=1, go to IDLE and set rr_ptr = grant_id+1 mod NUM_INPUTS.
- Credit counter update per cycle (accept = out.valid && out.ready):
  - accept && !credit_return: decrement.
  - !accept && credit_return: increment.
  - Both or neither: unchanged.
  - A return arriving when the count is 0 allows a same-cycle beat (bypass); the count stays 0.
- Overflow: a credit_return with credits_avail==MAX_IN_TRANSIT and no accept saturates at MAX_IN_TRANSIT.
- Counter width is $clog2(MAX_IN_TRANSIT)+1 bits; it never underflows, because a beat is only accepted when pass=1.
- Combinational paths: out.valid and in.ready may depend combinationally on out.ready, in.valid and credit_return. No registers sit in the data path; data latency is 0 cycles in LOCKED.
- A packet stalled on credits keeps its grant; no preemption.
- Valid requests from inputs other than grant_id are ignored until IDLE.
- Reset mid-packet: outstanding credits are forgotten and the pool is restored to MAX. Downstream must be reset together with the arbiter.
- NUM_INPUTS not a power of two: rr_ptr wraps at NUM_INPUTS-1 to 0, never at the 2^n boundary.

Optional Feature:
- Macro: CREDIT_ARBITER_CHECK_EN.
- Defined:
  - err is set on the first saturated credit return and held until reset.
  - Simulation assertions fire $fatal on three conditions:
    - X on credit_return after reset;
    - a change of in[grant_id].data/last while valid && !ready;
    - overflow.
- Undefined: err is tied to 0 and no assertions are compiled. Saturation behaviour is unchanged.

Decomposition:
- Package crossbar_pkg:
  - arb_state_t enum {IDLE, LOCKED};
  - function rr_next(ptr, valid_vector) returning the first valid index at or after ptr, with wrap.
- One natural sub-module: credit_counter, holding the credit counter with its bypass and saturation logic (and err when enabled). The existing credit-gating logic can later be refactored onto it.
- Stream muxing and the FSM stay in credit_arbiter.

Test Plan:
1. NUM_INPUTS=4, MAX=16, all inputs valid with 2-beat packets, out.ready=1, credit_return pulsed per accepted beat one cycle later -> grant order 0,1,2,3,0; exactly 1 idle cycle between packets; credits_avail never below 15.
2. Single input 2 valid with a 20-beat packet, no returns -> exactly 16 beats pass; then out.valid=0 and in[2].ready=0 with credits_avail=0; one credit_return pulse -> exactly 1 more beat passes in that same cycle.
3. credits_avail=0, then credit_return=1 and an accepted beat in the same cycle -> beat passes and credits_avail stays 0; at credits_avail=5, simultaneous accept and return -> stays 5.
4. rr_ptr=3 with only inputs 1 and 2 valid -> input 1 granted; after its last beat, input 2 is granted next.
5. 17 credit_return pulses with no traffic from reset -> credits_avail stays 16; err=1 if CREDIT_ARBITER_CHECK_EN is defined, else 0.
6. rst_n=0 asserted at the third beat of a packet with credits_avail=13 -> next cycle: IDLE, busy=0, credits_avail=16, out.valid=0.
